// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the 5-stage core.
//
// Combines per-stage stall requests into hold enables for the five pipeline registers. Sequences
// exception/ERET redirects as a single-cycle flush carrying a target PC. A watchdog also flags
// stalls that run too long.
//
// Ports:
//   clk            core clock; all state changes on the rising edge
//   rst            synchronous reset, active-low
//   stall_from_if  IF waiting on the instruction bus
//   stall_from_id  ID load-use hazard
//   stall_from_ex  EX multi-cycle operation busy
//   stall_from_mem MEM waiting on the data bus
//   exc_req        exception detected at MEM (level)
//   exc_handler    exception vector address
//   eret_req       ERET committing at MEM
//   epc_in         ERET return address
//   stall[4:0]     hold enables: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB
//   flush          clear all pipeline registers and load PC from flush_pc
//   flush_pc       redirect target, valid while flush=1
//   watchdog_trip  one-cycle pulse when a stall exceeds STALL_LIMIT cycles
module pipeline_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WDT_WIDTH   = 12,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_from_if,
  input  logic                  stall_from_id,
  input  logic                  stall_from_ex,
  input  logic                  stall_from_mem,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_handler,
  input  logic                  eret_req,
  input  logic [ADDR_WIDTH-1:0] epc_in,
  output logic [4:0]            stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  watchdog_trip
);

  localparam logic [WDT_WIDTH-1:0] WdtMax = WDT_WIDTH'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {StRun, StPend, StFlush} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic                  flush_q;
  logic [WDT_WIDTH-1:0]  wdt_q, wdt_d;
  logic                  trip_q, trip_d;

  logic                  redirect_req;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  assign redirect_req = exc_req | eret_req;
  // Exception wins over ERET when both arrive together.
  assign redirect_tgt = exc_req ? exc_handler : epc_in;

  // State register. Reset drops any pending redirect and clears the captured target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StRun;
      target_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      flush_q  <= (state_d == StFlush);
    end
  end

  // Next-state logic. The target is captured only on leaving RUN. Requests that arrive in PEND
  // or FLUSH cannot overwrite it.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      StRun: begin
        if (redirect_req) begin
          target_d = redirect_tgt;
          // A MEM bus transfer in flight must complete before the pipeline is cleared.
          state_d  = stall_from_mem ? StPend : StFlush;
        end
      end
      StPend: begin
        if (!stall_from_mem) state_d = StFlush;
      end
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Output logic. Stall is combinational. Flush and flush_pc come straight from flops.
  always_comb begin
    stall = 5'b00000;
    if (rst) begin
      unique case (state_q)
        StRun: begin
          if (stall_from_mem)     stall = 5'b01111;
          else if (stall_from_ex) stall = 5'b00111;
          else if (stall_from_id) stall = 5'b00011;
          else if (stall_from_if) stall = 5'b00001;
          else                    stall = 5'b00000;
        end
        StPend:  stall = 5'b01111;
        StFlush: stall = 5'b00000;
        default: stall = 5'b00000;
      endcase
    end
  end

  assign flush    = flush_q;
  assign flush_pc = target_q;

  // Watchdog: counts consecutive stalled cycles. Any unstalled cycle clears the count, and FLUSH
  // is always unstalled. When the limit is reached, the next cycle pulses the trip output and the
  // count restarts.
  always_comb begin
    wdt_d  = '0;
    trip_d = 1'b0;
    if (stall != 5'b00000) begin
      if (wdt_q == WdtMax) begin
        trip_d = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdt_q  <= '0;
      trip_q <= 1'b0;
    end else begin
      wdt_q  <= wdt_d;
      trip_q <= trip_d;
    end
  end

  assign watchdog_trip = trip_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (STALL_LIMIT=8). Each stimulus cycle pushes the
// hand-computed outputs expected during that cycle. A separate monitor pops and compares them at
// the falling edge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_from_if = 1'b0, stall_from_id = 1'b0;
  logic        stall_from_ex = 1'b0, stall_from_mem = 1'b0;
  logic        exc_req = 1'b0, eret_req = 1'b0;
  logic [31:0] exc_handler = '0, epc_in = '0;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        watchdog_trip;

  pipeline_ctrl #(
    .ADDR_WIDTH (32),
    .WDT_WIDTH  (12),
    .STALL_LIMIT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_from_if (stall_from_if),
    .stall_from_id (stall_from_id),
    .stall_from_ex (stall_from_ex),
    .stall_from_mem(stall_from_mem),
    .exc_req       (exc_req),
    .exc_handler   (exc_handler),
    .eret_req      (eret_req),
    .epc_in        (epc_in),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .watchdog_trip (watchdog_trip)
  );

  always #5 clk = ~clk;

  // Request bundle order: {mem, ex, id, if}
  localparam logic [3:0] RM = 4'b1000, RE = 4'b0100, RI = 4'b0010, RF = 4'b0001, RN = 4'b0000;
  localparam logic [4:0] SM = 5'b01111, SE = 5'b00111, SI = 5'b00011, SF = 5'b00001, S0 = 5'b0;
  localparam logic [31:0] HND = 32'hBFC0_0380, EPC = 32'h8000_1000;

  typedef struct {
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        chk_pc;
    logic        trip;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
    else n_pass++;
  endtask

  // One cycle: apply inputs just after the rising edge and queue the outputs expected in it.
  task automatic cyc(input logic r, input logic [3:0] req, input logic exc, input logic eret,
                     input logic [31:0] hnd, input logic [31:0] epc, input logic [4:0] es,
                     input logic ef, input logic [31:0] ep, input logic cp, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    {stall_from_mem, stall_from_ex, stall_from_id, stall_from_if} = req;
    exc_req = exc;
    eret_req = eret;
    exc_handler = hnd;
    epc_in = epc;
    e.stall = es; e.flush = ef; e.pc = ep; e.chk_pc = cp; e.trip = et; e.id = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  task automatic idle(input logic et);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b0, '0, 1'b0, et);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("stall", mon_e.id, {27'b0, stall}, {27'b0, mon_e.stall});
      chk("flush", mon_e.id, {31'b0, flush}, {31'b0, mon_e.flush});
      chk("watchdog_trip", mon_e.id, {31'b0, watchdog_trip}, {31'b0, mon_e.trip});
      if (mon_e.chk_pc) chk("flush_pc", mon_e.id, flush_pc, mon_e.pc);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset: requests are ignored and all outputs are zero.
    cyc(1'b0, RM | RE, 1'b1, 1'b1, HND, EPC, S0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, RM, 1'b1, 1'b0, HND, EPC, S0, 1'b0, '0, 1'b1, 1'b0);

    // Stall priority.
    cyc(1'b1, RI | RE, 1'b0, 1'b0, '0, '0, SE, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, RI | RE | RM, 1'b0, 1'b0, '0, '0, SM, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RF, 1'b0, 1'b0, '0, '0, SF, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RI | RF, 1'b0, 1'b0, '0, '0, SI, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);

    // Exception without MEM wait. The FLUSH cycle ignores a stale ID stall and the held exc_req.
    cyc(1'b1, RN, 1'b1, 1'b0, HND, '0, S0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RI, 1'b1, 1'b0, HND, '0, S0, 1'b1, HND, 1'b1, 1'b0);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b0, HND, 1'b1, 1'b0);
    idle(1'b0);

    // Exception during a 3-cycle MEM wait. A later handler change and an eret are not captured.
    cyc(1'b1, RM, 1'b1, 1'b0, 32'h9000_0180, '0, SM, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RM, 1'b1, 1'b1, 32'h1111_1111, EPC, SM, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RM, 1'b0, 1'b0, 32'h1111_1111, '0, SM, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RI, 1'b0, 1'b0, '0, '0, SM, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b1, 32'h9000_0180, 1'b1, 1'b0);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b0, 32'h9000_0180, 1'b1, 1'b0);

    // Simultaneous exc and eret: the exception target wins.
    cyc(1'b1, RN, 1'b1, 1'b1, HND, EPC, S0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b1, HND, 1'b1, 1'b0);
    idle(1'b0);

    // ERET alone.
    cyc(1'b1, RN, 1'b0, 1'b1, HND, EPC, S0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b1, EPC, 1'b1, 1'b0);
    cyc(1'b1, RN, 1'b0, 1'b0, '0, '0, S0, 1'b0, EPC, 1'b1, 1'b0);

    // Watchdog: 20 stalled cycles pulse the trip in cycles 9 and 17.
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, RM, 1'b0, 1'b0, '0, '0, SM, 1'b0, '0, 1'b0, (i == 9 || i == 17));
    end
    idle(1'b0);
    idle(1'b0);

    // A gap at cycle 5 restarts the count, so the first pulse moves to cycle 14.
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) idle(1'b0);
      else cyc(1'b1, RM, 1'b0, 1'b0, '0, '0, SM, 1'b0, '0, 1'b0, (i == 14));
    end
    idle(1'b0);

    // Reset while in PEND discards the redirect.
    cyc(1'b1, RM, 1'b1, 1'b0, 32'hA000_0000, '0, SM, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, RM, 1'b0, 1'b0, '0, '0, S0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, RI, 1'b0, 1'b0, '0, '0, SI, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
